// File: rtl/jk_updown_counter_n_if.sv
// Control/observation bundle for jk_updown_counter_n.
// The slave side is the counter; the master side drives controls and watches state.
interface jk_updown_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             e;
    logic             x;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] ps;
    logic [WIDTH-1:0] ns;
    logic [WIDTH-1:0] tog;
    logic             tc;
    logic             wrap;

    modport slave (
        input  e, x, load, load_val,
        output ps, ns, tog, tc, wrap
    );

    modport master (
        output e, x, load, load_val,
        input  ps, ns, tog, tc, wrap
    );
endinterface

// File: rtl/jk_updown_counter_n.sv
// WIDTH-bit up/down counter on per-bit JK toggle flops, modulo MODULUS, with
// synchronous clamped load, wrap/saturate ends, terminal count and a wrap pulse.
module jk_updown_counter_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    jk_updown_counter_n_if.slave   bus
);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam bit               FULL_MOD = (MODULUS == (2 ** WIDTH));
    localparam bit               SAT_EN   = (SATURATE != 0);

    logic [WIDTH-1:0] ps_q;
    logic [WIDTH-1:0] ns_d;
    logic [WIDTH-1:0] tog_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_bot;
    logic             tc_d;
    logic             wrap_q;
    logic             wrap_d;

    always_comb begin
        at_top       = (ps_q == MAX_VAL);
        at_bot       = (ps_q == '0);
        load_clamped = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
        tc_d         = bus.e & ~bus.load & (bus.x ? at_top : at_bot);
        wrap_d       = SAT_EN ? 1'b0 : tc_d;
    end

    always_comb begin
        ns_d = ps_q;
        if (bus.load) begin
            ns_d = load_clamped;
        end else if (bus.e) begin
            if (bus.x) begin
                if (at_top) ns_d = SAT_EN ? ps_q : '0;
                else        ns_d = ps_q + WIDTH'(1);
            end else begin
                if (at_bot) ns_d = SAT_EN ? ps_q : MAX_VAL;
                else        ns_d = ps_q - WIDTH'(1);
            end
        end
    end

    generate
        if (FULL_MOD) begin : g_ripple
            // Power-of-two range: classic carry/borrow chains give the toggles directly.
            logic [WIDTH-1:0] up_chain;
            logic [WIDTH-1:0] dn_chain;

            always_comb begin
                up_chain[0] = 1'b1;
                dn_chain[0] = 1'b1;
                for (int i = 1; i < WIDTH; i++) begin
                    up_chain[i] = up_chain[i-1] &  ps_q[i-1];
                    dn_chain[i] = dn_chain[i-1] & ~ps_q[i-1];
                end
                tog_d = '0;
                if (bus.load) begin
                    tog_d = ps_q ^ load_clamped;
                end else if (bus.e && !(SAT_EN && tc_d)) begin
                    tog_d = bus.x ? up_chain : dn_chain;
                end
            end
        end else begin : g_diff
            assign tog_d = ps_q ^ ns_d;
        end
    endgenerate

    // J=K=tog[i]: each bit toggles when its term is set, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            ps_q   <= ps_q ^ tog_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.ps   = ps_q;
    assign bus.ns   = ns_d;
    assign bus.tog  = tog_d;
    assign bus.tc   = tc_d;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter_n.sv
// Directed bench for jk_updown_counter_n: modulo-10 wrap, modulo-16 saturate
// and a modulo-16 wrap instance with a toggle-term sweep.
module tb_jk_updown_counter_n;
    logic clk;
    logic rst;
    int   tests;
    int   failed;

    jk_updown_counter_n_if #(.WIDTH(4)) i10  ();
    jk_updown_counter_n_if #(.WIDTH(4)) i16s ();
    jk_updown_counter_n_if #(.WIDTH(4)) i16  ();

    jk_updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u10 (
        .clk (clk),
        .rst (rst),
        .bus (i10)
    );

    jk_updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1)) u16s (
        .clk (clk),
        .rst (rst),
        .bus (i16s)
    );

    jk_updown_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (i16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ns_model(input logic [3:0] p, input logic e, input logic x,
                                            input logic ld, input logic [3:0] lv,
                                            input int m, input bit sat);
        logic [3:0] top;
        top = 4'(m - 1);
        if (ld)  return (lv > top) ? top : lv;
        if (!e)  return p;
        if (x)   return (p == top) ? (sat ? p : 4'd0) : p + 4'd1;
        return (p == 4'd0) ? (sat ? 4'd0 : top) : p - 4'd1;
    endfunction

    logic [3:0] dn_exp [4];
    logic       dn_tc  [4];
    logic       dn_wr  [4];
    logic [3:0] mps;
    logic [3:0] exp_ns;
    logic [3:0] chain;
    logic       re, rx, rl;
    logic [3:0] rv;

    initial begin
        tests  = 0;
        failed = 0;
        dn_exp = '{4'd1, 4'd0, 4'd9, 4'd8};
        dn_tc  = '{1'b0, 1'b0, 1'b1, 1'b0};
        dn_wr  = '{1'b0, 1'b0, 1'b1, 1'b0};
        i10.e  = 0; i10.x  = 0; i10.load  = 0; i10.load_val  = '0;
        i16s.e = 0; i16s.x = 0; i16s.load = 0; i16s.load_val = '0;
        i16.e  = 0; i16.x  = 0; i16.load  = 0; i16.load_val  = '0;

        // Reset without clock
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_ps", 32'(i10.ps), 32'd0);
        chk("rst_wrap", 32'(i10.wrap), 32'd0);
        #1 rst = 1'b1;

        // Hold with e=0
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_ps", 32'(i10.ps), 32'd0);
            chk("hold_ns", 32'(i10.ns), 32'd0);
            chk("hold_tog", 32'(i10.tog), 32'd0);
        end

        // Count up to 5, then async reset mid-count
        i10.e = 1; i10.x = 1;
        #1;
        chk("up_ns0", 32'(i10.ns), 32'd1);
        chk("up_tog0", 32'(i10.tog), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("pre_rst_ps", 32'(i10.ps), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ps", 32'(i10.ps), 32'd0);
        chk("mid_rst_wrap", 32'(i10.wrap), 32'd0);
        chk("mid_rst_ns", 32'(i10.ns), 32'd1);
        #1 rst = 1'b1;

        // Up wrap, MODULUS=10
        for (int k = 1; k <= 12; k++) begin
            chk("upw_tc", 32'(i10.tc), ((k - 1) % 10 == 9) ? 32'd1 : 32'd0);
            tick();
            chk("upw_ps", 32'(i10.ps), 32'(k % 10));
            chk("upw_wrap", 32'(i10.wrap), (k == 10) ? 32'd1 : 32'd0);
        end

        // Down wrap from 2
        i10.x = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("dn_tc", 32'(i10.tc), 32'(dn_tc[k]));
            tick();
            chk("dn_ps", 32'(i10.ps), 32'(dn_exp[k]));
            chk("dn_wrap", 32'(i10.wrap), 32'(dn_wr[k]));
        end

        // Direction flip
        i10.x = 1;
        #1;
        chk("flip_ns", 32'(i10.ns), 32'd9);
        tick();
        chk("flip_ps", 32'(i10.ps), 32'd9);
        chk("flip_wrap", 32'(i10.wrap), 32'd0);

        // Load at range end beats the wrap
        i10.load = 1; i10.load_val = 4'd7;
        #1;
        chk("ld_tc", 32'(i10.tc), 32'd0);
        chk("ld_ns", 32'(i10.ns), 32'd7);
        tick();
        chk("ld_ps", 32'(i10.ps), 32'd7);
        chk("ld_wrap", 32'(i10.wrap), 32'd0);
        i10.load_val = 4'd12;
        #1;
        chk("ldc_ns", 32'(i10.ns), 32'd9);
        tick();
        chk("ldc_ps", 32'(i10.ps), 32'd9);
        i10.load_val = 4'd3;
        #1;
        chk("ld9_tc", 32'(i10.tc), 32'd0);
        tick();
        chk("ld9_ps", 32'(i10.ps), 32'd3);
        chk("ld9_wrap", 32'(i10.wrap), 32'd0);
        i10.load = 0; i10.e = 0;

        // Saturate, MODULUS=16
        i16s.load = 1; i16s.load_val = 4'd14;
        tick();
        chk("sat_ld", 32'(i16s.ps), 32'd14);
        i16s.load = 0; i16s.e = 1; i16s.x = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("sat_ps", 32'(i16s.ps), 32'd15);
            chk("sat_tc", 32'(i16s.tc), 32'd1);
            chk("sat_wrap", 32'(i16s.wrap), 32'd0);
            chk("sat_tog", 32'(i16s.tog), 32'd0);
        end
        i16s.load = 1; i16s.load_val = 4'd1;
        tick();
        i16s.load = 0; i16s.x = 0;
        #1;
        chk("satd_tc1", 32'(i16s.tc), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("satd_ps", 32'(i16s.ps), 32'd0);
            chk("satd_tc", 32'(i16s.tc), 32'd1);
            chk("satd_wrap", 32'(i16s.wrap), 32'd0);
            chk("satd_ns", 32'(i16s.ns), 32'd0);
        end
        i16s.e = 0;

        // Ripple toggle at 0111 up
        i16.load = 1; i16.load_val = 4'd7;
        tick();
        i16.load = 0; i16.e = 1; i16.x = 1;
        #1;
        chk("rip_tog", 32'(i16.tog), 32'hF);
        chk("rip_ns", 32'(i16.ns), 32'd8);

        // Random sweep against the reference model
        mps = 4'd7;
        for (int k = 0; k < 40; k++) begin
            re = 1'($urandom); rx = 1'($urandom);
            rl = ($urandom_range(0, 4) == 0);
            rv = 4'($urandom);
            i16.e = re; i16.x = rx; i16.load = rl; i16.load_val = rv;
            #1;
            exp_ns = ns_model(mps, re, rx, rl, rv, 16, 1'b0);
            chk("rnd_ns", 32'(i16.ns), 32'(exp_ns));
            chk("rnd_tog", 32'(i16.tog), 32'(mps ^ exp_ns));
            if (!rl && rx) begin
                chain[0] = re;
                for (int b = 1; b < 4; b++) chain[b] = chain[b-1] & mps[b-1];
                chk("rnd_ripple", 32'(i16.tog), 32'(chain));
            end
            tick();
            mps = exp_ns;
            chk("rnd_ps", 32'(i16.ps), 32'(mps));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/jk_updown_counter_n.md
Name: jk_updown_counter_n

Overview:
Parametrised up/down counter built on per-bit JK toggle logic, with enable and direction inputs, synchronous load, programmable modulus and a wrap/saturate mode. It exposes present state, next state and per-bit toggle terms so surrounding FSM blocks can observe the counter. It generalises the team's 2-bit enable/direction JK counter to WIDTH bits with terminal-count and wrap flags.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MODULUS, 16, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
e  in  1  count enable
x  in  1  direction: 1 = up, 0 = down
load  in  1  synchronous load strobe
load_val  in  WIDTH  value to load
ps  out  WIDTH  present state (registered)
ns  out  WIDTH  next state (combinational)
tog  out  WIDTH  per-bit JK toggle terms, J=K=tog[i], equals ps^ns (combinational)
tc  out  1  terminal count (combinational)
wrap  out  1  registered one-cycle pulse after a wrap

Behaviour:
- Reset: rst low forces ps=0 and wrap=0 immediately, independent of clk. While rst is low, ns/tog/tc track ps=0 and the inputs. The first count edge is the first rising clk with rst high.
- State update: on each rising clk with rst high, ps <= ns. Flops are JK with J=K=tog[i], so ps[i] toggles when tog[i]=1. This is equivalent to ps <= ns.
- ns priority:
  1. load=1: ns = load_val if load_val <= MODULUS-1, otherwise MODULUS-1 (clamped). e and x are ignored.
  2. load=0, e=0: ns = ps (hold).
  3. load=0, e=1, x=1: ns = ps+1. At ps==MODULUS-1, ns = 0 (SATURATE=0) or ps (SATURATE=1).
  4. load=0, e=1, x=0: ns = ps-1. At ps==0, ns = MODULUS-1 (SATURATE=0) or 0 (SATURATE=1).
- Arithmetic is modulo MODULUS, not 2**WIDTH. An out-of-range ps (>=MODULUS) cannot be reached from reset or load.
- When MODULUS = 2**WIDTH, toggle terms reduce to the classic ripple form. Up: tog[i] = e & AND(ps[i-1:0]). Down: tog[i] = e & AND(~ps[i-1:0]). tog[0] = e. Both forms must match ns exactly.
- tc = e & ~load & (x ? ps==MODULUS-1 : ps==0). tc is asserted in both SATURATE modes.
- wrap: registered; wrap <= tc & (SATURATE==0). It is high for exactly the one cycle after ps jumped across the range end. It is never set on a load or in SATURATE=1.
- Direction change mid-count: takes effect on the next edge, with no extra latency or bubble.
- Simultaneous load and range-end count: load wins, tc=0, and no wrap pulse follows.
- Latency: ps reflects inputs one clk after sampling. ns, tog and tc are zero-latency combinational.
- No X propagation: outputs are defined whenever rst is high and the inputs are known.

Test Plan:
- Reset/hold: rst=0 mid-count at ps=5 -> ps=0 and wrap=0 within the same timestep, no clk needed. Release rst with e=0 for 3 clks -> ps stays 0, ns=0, tog=0.
- Up wrap (WIDTH=4, MODULUS=10): e=1, x=1 from 0 for 12 clks -> ps goes 0..9,0,1. tc high only while ps=9. wrap high for one cycle with ps=0.
- Down wrap and direction flip (MODULUS=10): from ps=2, x=0 for 4 clks -> 1,0,9,8. tc high at ps=0. Then x=1 -> 9 on the next clk.
- Saturate (SATURATE=1, MODULUS=16): count up from 14 for 4 clks -> 15,15,15,15 with tc=1 and wrap=0 throughout. x=0 from 1 -> 0,0 with tc=1.
- Load: load=1, load_val=7, e=1, x=1 at ps=9 (MODULUS=10) -> ps=7, tc=0, no wrap. load_val=12 -> ps=9 (clamped).
- Toggle check (MODULUS=16): over a 40-cycle random sweep of e, x and load, every cycle tog==ps^ns. With load=0 and in the up direction, tog[i] equals e & AND(ps[i-1:0]), e.g. ps=0111 -> tog=1111.
